// File: rtl/alu_issue_wb_if.sv
// Handshake, ALU operand/result and debug bus for the alu_issue_wb sequencer.
// slave = the sequencer; master = the instruction source, ALU model and debug reader.
interface alu_issue_wb_if #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_r;
    logic              alu_cf;
    logic              alu_sf;
    logic              alu_zf;
    logic [2:0]        flags;
    logic              done;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  alu_r, alu_cf, alu_sf, alu_zf, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op, flags, done, dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output alu_r, alu_cf, alu_sf, alu_zf, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op, flags, done, dbg_data
    );
endinterface

// File: rtl/alu_issue_wb.sv
// Issue/writeback sequencer and register file around a combinational 5-bit ALU.
// Optional macro ALU_ISSUE_ZERO_REG_EN hardwires register 0 to zero.
module alu_issue_wb #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 2,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_wb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state_r;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [ADDR_W-1:0] rs1_r;
    logic [ADDR_W-1:0] rs2_r;
    logic [DATA_W-1:0] imm_r;
    logic [DATA_W-1:0] result_r;
    logic [2:0]        flags_r;
    logic              done_r;
    logic              ready_r;
    logic [DATA_W-1:0] regs_r [NREG];

    // Register read port shared by both operands and the debug port.
    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val_s;
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (addr == {ADDR_W{1'b0}}) begin
            val_s = {DATA_W{1'b0}};
        end else begin
            val_s = regs_r[addr];
        end
`else
        val_s = regs_r[addr];
`endif
        return val_s;
    endfunction

    // Operands follow the latched fields, so they hold steady outside EXEC.
    assign bus.alu_a    = read_reg(rs1_r);
    assign bus.alu_b    = read_reg(rs2_r);
    assign bus.alu_op   = op_r;
    assign bus.dbg_data = read_reg(bus.dbg_addr);
    assign bus.in_ready = ready_r;
    assign bus.done     = done_r;
    assign bus.flags    = flags_r;

    // Sequencer FSM, latched instruction, result/flags capture and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 2'b00;
            rd_r     <= {ADDR_W{1'b0}};
            rs1_r    <= {ADDR_W{1'b0}};
            rs2_r    <= {ADDR_W{1'b0}};
            imm_r    <= {DATA_W{1'b0}};
            result_r <= {DATA_W{1'b0}};
            flags_r  <= 3'b000;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.in_valid && ready_r) begin
                        op_r    <= bus.in_op;
                        rd_r    <= bus.in_rd;
                        rs1_r   <= bus.in_rs1;
                        rs2_r   <= bus.in_rs2;
                        imm_r   <= bus.in_imm;
                        ready_r <= 1'b0;
                        state_r <= EXEC;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    // LDI bypasses the ALU and leaves the flags alone.
                    if (op_r == 2'b11) begin
                        result_r <= imm_r;
                    end else begin
                        result_r <= bus.alu_r;
                        flags_r  <= {bus.alu_cf, bus.alu_sf, bus.alu_zf};
                    end
                    done_r  <= 1'b1;
                    ready_r <= 1'b0;
                    state_r <= WB;
                end
                WB: begin
`ifdef ALU_ISSUE_ZERO_REG_EN
                    if (rd_r != {ADDR_W{1'b0}}) begin
                        regs_r[rd_r] <= result_r;
                    end else begin
                        regs_r[rd_r] <= {DATA_W{1'b0}};
                    end
`else
                    regs_r[rd_r] <= result_r;
`endif
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed scoreboard bench for alu_issue_wb; honours ALU_ISSUE_ZERO_REG_EN in its model.
module tb_alu_issue_wb;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [1:0] rd;
        logic [4:0] res;
        logic [2:0] fl;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] model_reg [4];
    logic [2:0] model_flags;
    logic [1:0] g_op;
    logic [1:0] g_rd;
    logic [1:0] g_rs1;
    logic [1:0] g_rs2;
    logic [4:0] g_imm;

    alu_issue_wb_if #(.DATA_W(5), .ADDR_W(2)) bus ();

    alu_issue_wb #(.DATA_W(5), .ADDR_W(2), .NREG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] mread(input logic [1:0] a);
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (a == 2'd0) return 5'd0;
`endif
        return model_reg[a];
    endfunction

    task automatic mwrite(input logic [1:0] a, input logic [4:0] d);
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (a == 2'd0) return;
`endif
        model_reg[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_reg[i] = 5'd0;
        model_flags = 3'b000;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+2 in IDLE after writeback.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [4:0] imm, input logic [4:0] r,
                         input logic cf, input logic sf, input logic zf, input bit keep_valid);
        exp_t       e;
        logic [4:0] exp_a;
        logic [4:0] exp_b;
        exp_a = mread(rs1);
        exp_b = mread(rs2);
        e.rd  = rd;
        e.res = (op == 2'b11) ? imm : r;
        e.fl  = (op == 2'b11) ? model_flags : {cf, sf, zf};
        sb.push_back(e);
        chk("ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        bus.alu_r = r; bus.alu_cf = cf; bus.alu_sf = sf; bus.alu_zf = zf;
        @(posedge clk); #1;
        // EXEC: perturb inputs, which must not affect the latched instruction
        if (keep_valid) begin
            bus.in_op = g_op; bus.in_rd = g_rd; bus.in_rs1 = g_rs1; bus.in_rs2 = g_rs2; bus.in_imm = g_imm;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_op = ~op; bus.in_rd = ~rd; bus.in_rs1 = ~rs1; bus.in_rs2 = ~rs2; bus.in_imm = ~imm;
        end
        #1;
        chk("exec_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("exec_done", {31'd0, bus.done}, 32'd0);
        chk("exec_alu_a", {27'd0, bus.alu_a}, {27'd0, exp_a});
        chk("exec_alu_b", {27'd0, bus.alu_b}, {27'd0, exp_b});
        chk("exec_alu_op", {30'd0, bus.alu_op}, {30'd0, op});
        @(posedge clk); #1;
        chk("wb_done", {31'd0, bus.done}, 32'd1);
        chk("wb_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("wb_alu_a_hold", {27'd0, bus.alu_a}, {27'd0, exp_a});
        chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_flags", {29'd0, bus.flags}, {29'd0, e.fl});
            model_flags = e.fl;
            mwrite(e.rd, e.res);
        end
        @(posedge clk); #1;
        chk("idle_done", {31'd0, bus.done}, 32'd0);
        chk("idle_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.dbg_addr = rd;
        #1;
        chk("wb_dbg", {27'd0, bus.dbg_data}, {27'd0, mread(rd)});
    endtask

    initial begin
        checks = 0; errors = 0;
        model_clear();
        g_op = 2'b00; g_rd = 2'd0; g_rs1 = 2'd0; g_rs2 = 2'd0; g_imm = 5'd0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_rd = 2'd0; bus.in_rs1 = 2'd0;
        bus.in_rs2 = 2'd0; bus.in_imm = 5'd0; bus.alu_r = 5'd0; bus.alu_cf = 1'b0;
        bus.alu_sf = 1'b0; bus.alu_zf = 1'b0; bus.dbg_addr = 2'd0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        // 1: reset state
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_flags", {29'd0, bus.flags}, 32'd0);
        chk("rst_alu_a", {27'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b", {27'd0, bus.alu_b}, 32'd0);
        chk("rst_alu_op", {30'd0, bus.alu_op}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.dbg_addr = 2'(a);
            #1;
            chk("rst_dbg", {27'd0, bus.dbg_data}, 32'd0);
        end
        // 2: two loads, flags stay clear
        issue(2'b11, 2'd1, 2'd0, 2'd0, 5'b10101, 5'b01110, 1'b1, 1'b1, 1'b1, 1'b0);
        issue(2'b11, 2'd2, 2'd3, 2'd1, 5'b10001, 5'b00000, 1'b0, 0, 0, 1'b0);
        chk("ldi_flags", {29'd0, bus.flags}, 32'd0);
        // 3: ALU op r3 = f(r1, r2)
        issue(2'b00, 2'd3, 2'd1, 2'd2, 5'b00000, 5'b00110, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("op00_flags", {29'd0, bus.flags}, 32'b100);
        // 4: aliased source/destination
        issue(2'b01, 2'd1, 2'd1, 2'd1, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("alias_flags", {29'd0, bus.flags}, 32'b001);
        // 5: valid held high; next instruction visible during EXEC/WB
        g_op = 2'b11; g_rd = 2'd2; g_rs1 = 2'd1; g_rs2 = 2'd3; g_imm = 5'b01010;
        issue(2'b10, 2'd0, 2'd3, 2'd1, 5'b11100, 5'b00110, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(g_op, g_rd, g_rs1, g_rs2, g_imm, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("held_flags", {29'd0, bus.flags}, 32'b010);
        // 6: reset during EXEC drops the write and clears state
        bus.in_valid = 1'b1; bus.in_op = 2'b10; bus.in_rd = 2'd2; bus.in_rs1 = 2'd2;
        bus.in_rs2 = 2'd3; bus.alu_r = 5'b11111; bus.alu_cf = 1'b1; bus.alu_sf = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid_exec_ready", {31'd0, bus.in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_flags", {29'd0, bus.flags}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        model_clear();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("post_rst_done", {31'd0, bus.done}, 32'd0);
        end
        for (int a = 0; a < 4; a++) begin
            bus.dbg_addr = 2'(a);
            #1;
            chk("post_rst_dbg", {27'd0, bus.dbg_data}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        // Load into r0 (zeroed when the hardwired-zero option is built in)
        issue(2'b11, 2'd0, 2'd1, 2'd2, 5'b11111, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 2'd3, 2'd0, 2'd0, 5'b00000, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
Sequencer and register file that sits directly upstream and downstream of the 5-bit ALU. It accepts one instruction per handshake and reads two source registers onto the ALU operands a and b. It then captures the ALU result R and the flags cf/sf/zf, and writes the result back to a destination register. Op 2'b11 is a load-immediate handled locally, without the ALU.

Parameters:
DATA_W, 5, register and ALU datapath width; must match the ALU width.
NREG, 4, number of general registers.
ADDR_W, 2, register address width; NREG = 2**ADDR_W.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  instruction offered.
in_ready  output  1  block can accept an instruction.
in_op  input  2  00/01/10 = ALU op passed through; 11 = load immediate (LDI).
in_rd  input  ADDR_W  destination register.
in_rs1  input  ADDR_W  source register for operand a.
in_rs2  input  ADDR_W  source register for operand b.
in_imm  input  DATA_W  immediate, used by LDI only.
alu_a  output  DATA_W  ALU operand a.
alu_b  output  DATA_W  ALU operand b.
alu_op  output  2  ALU op.
alu_r  input  DATA_W  ALU result R (combinational from ALU).
alu_cf  input  1  ALU carry flag.
alu_sf  input  1  ALU sign flag.
alu_zf  input  1  ALU zero flag.
flags  output  3  latched {cf,sf,zf}.
done  output  1  one-cycle pulse when writeback occurs.
dbg_addr  input  ADDR_W  debug read address.
dbg_data  output  DATA_W  combinational read of register dbg_addr.

Behaviour:
- Reset (rst_n low, async): state IDLE; all registers 0; latched instruction fields 0; result register 0; flags 3'b000; done 0. Consequently alu_a = alu_b = 0, alu_op = 00, in_ready = 1 once reset is released.
- FSM states: IDLE -> EXEC -> WB -> IDLE. Each instruction takes exactly 3 cycles; at most one instruction is in flight.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: latch op, rd, rs1, rs2, imm; go to EXEC.
  - in_valid low: stay in IDLE.
- EXEC:
  - in_ready = 0.
  - alu_a = reg[rs1_q], alu_b = reg[rs2_q], alu_op = op_q (combinational from latched fields and registers).
  - At the end of the cycle:
    - ALU op: result_q <= alu_r; flags <= {alu_cf, alu_sf, alu_zf}.
    - LDI: result_q <= imm_q; flags unchanged.
  - Go to WB.
- WB:
  - in_ready = 0; done = 1 for this cycle only.
  - reg[rd_q] <= result_q at the end of the cycle; go to IDLE.
- Operand hold: alu_a, alu_b and alu_op keep their values outside EXEC; they change only when the latched fields or registers change.
- Ignored inputs:
  - in_valid and all in_* are ignored outside IDLE.
  - Changes to in_* after acceptance have no effect.
- No hazards: the next instruction reads registers only after the previous writeback has completed.
- Aliasing: rd may equal rs1 or rs2; the old value is the one used as operand.
- Reset mid-operation (EXEC or WB): immediate return to IDLE. The pending write is lost, done drops to 0, and all registers and flags are cleared.
- dbg_data: combinational read of reg[dbg_addr], independent of state.

Optional Feature:
ALU_ISSUE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Reads of r0 (alu_a, alu_b, dbg_data) return 0; writeback to rd = 0 is discarded. done still pulses, and flags still update for ALU ops.
- Undefined: r0 is an ordinary register.

Test Plan:
1. Reset -> in_ready=1, done=0, flags=000, dbg_data=0 for every address, alu_a=alu_b=0.
2. LDI rd=1 imm=10101, then LDI rd=2 imm=10001 -> each: done pulses exactly 2 cycles after acceptance; dbg r1=10101, r2=10001; flags stay 000.
3. op=00 rd=3 rs1=1 rs2=2; bench drives alu_r=00110, cf=1, sf=0, zf=0 during EXEC -> alu_a=10101, alu_b=10001, alu_op=00 in EXEC; done pulses 2 cycles after acceptance; r3=00110; flags=100.
4. op=01 rd=1 rs1=1 rs2=1 with alu_r=00000, zf=1 -> alu_a=alu_b=10101; after WB r1=00000, flags=001.
5. in_valid held high continuously, with fields changed during EXEC -> second instruction accepted only on the IDLE cycle after WB; the first instruction's latched fields are unaffected.
6. rst_n pulsed low mid-EXEC of op=10 rd=2 -> no done pulse, r2=0, flags=000, in_ready=1 after release. With ALU_ISSUE_ZERO_REG_EN: LDI rd=0 imm=11111 -> done pulses, dbg r0 = 00000.
